// File: rtl/ex_pkg.sv
// Shared constants for the MIPS execute stage: ALU op codes, in_ex control bit
// positions and the link register index.
package ex_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD   = 4'd0;
  localparam alu_op_t ALU_SUB   = 4'd1;
  localparam alu_op_t ALU_AND   = 4'd2;
  localparam alu_op_t ALU_OR    = 4'd3;
  localparam alu_op_t ALU_XOR   = 4'd4;
  localparam alu_op_t ALU_NOR   = 4'd5;
  localparam alu_op_t ALU_SLT   = 4'd6;
  localparam alu_op_t ALU_SLTU  = 4'd7;
  localparam alu_op_t ALU_SLL   = 4'd8;
  localparam alu_op_t ALU_SRL   = 4'd9;
  localparam alu_op_t ALU_SRA   = 4'd10;
  localparam alu_op_t ALU_SLLV  = 4'd11;
  localparam alu_op_t ALU_SRLV  = 4'd12;
  localparam alu_op_t ALU_SRAV  = 4'd13;
  localparam alu_op_t ALU_LUI   = 4'd14;
  localparam alu_op_t ALU_PASSA = 4'd15;

  localparam int EX_REGDST   = 7;
  localparam int EX_ALUSRC   = 6;
  localparam int EX_ALUOP_HI = 5;
  localparam int EX_ALUOP_LO = 2;
  localparam int EX_LINK     = 1;

  localparam int LINK_REG = 31;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU for the execute stage: arithmetic, logic, compare, shift
// and LUI on operands A/B, with fixed (shamt) or variable (A[4:0]) shifts.
module ex_alu
  import ex_pkg::*;
#(
  parameter int NB_data = 32,
  parameter int NB_addr = 5
) (
  input  logic [NB_data-1:0] a_i,
  input  logic [NB_data-1:0] b_i,
  input  logic [NB_addr-1:0] shamt_i,
  input  alu_op_t            op_i,
  output logic [NB_data-1:0] result_o
);

  localparam int SHW = $clog2(NB_data);

  logic [SHW-1:0] var_sh;
  assign var_sh = a_i[SHW-1:0];

  always_comb begin
    // NOTE: default first so every path assigns result_o and no latch is inferred.
    result_o = '0;
    unique case (op_i)
      ALU_ADD:   result_o = a_i + b_i;
      ALU_SUB:   result_o = a_i - b_i;
      ALU_AND:   result_o = a_i & b_i;
      ALU_OR:    result_o = a_i | b_i;
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_NOR:   result_o = ~(a_i | b_i);
      ALU_SLT:   result_o = NB_data'($signed(a_i) < $signed(b_i));
      ALU_SLTU:  result_o = NB_data'(a_i < b_i);
      ALU_SLL:   result_o = b_i << shamt_i;
      ALU_SRL:   result_o = b_i >> shamt_i;
      ALU_SRA:   result_o = $signed(b_i) >>> shamt_i;
      ALU_SLLV:  result_o = b_i << var_sh;
      ALU_SRLV:  result_o = b_i >> var_sh;
      ALU_SRAV:  result_o = $signed(b_i) >>> var_sh;
      ALU_LUI:   result_o = b_i << 16;
      ALU_PASSA: result_o = a_i;
      default:   result_o = a_i;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage plus EX/MEM pipeline register. Define EX_LINK_EN to let
// in_ex[1] replace the ALU result with PC+4 and force the destination to r31.
module ex_stage
  import ex_pkg::*;
#(
  parameter int NB_data = 32,
  parameter int NB_addr = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NB_data-1:0] in_branch,
  input  logic [7:0]         in_ex,
  input  logic [2:0]         in_mem,
  input  logic [1:0]         in_wb,
  input  logic [NB_data-1:0] in_reg1,
  input  logic [NB_data-1:0] in_reg2,
  input  logic [NB_data-1:0] in_inmediato,
  input  logic [25:0]        in_jump_reg,
  input  logic [NB_addr-1:0] in_shamt,
  input  logic [NB_addr-1:0] in_rt,
  input  logic [NB_addr-1:0] in_rd,
  output logic [NB_data-1:0] out_branch,
  output logic [NB_data-1:0] out_alu,
  output logic [NB_addr-1:0] out_reg_dest,
  output logic [NB_data-1:0] out_w_data,
  output logic               out_zero,
  output logic               out_sign,
  output logic [2:0]         out_mem,
  output logic [1:0]         out_wb,
  output logic [25:0]        out_jump_reg
);

  logic [NB_data-1:0] op_b;
  logic [NB_data-1:0] alu_res;
  logic [NB_data-1:0] alu_d;
  logic [NB_addr-1:0] dest_d;
  logic [NB_data-1:0] branch_d;
  logic               zero_d;
  logic               sign_d;
  alu_op_t            alu_op;

  logic [NB_data-1:0] branch_q;
  logic [NB_data-1:0] alu_q;
  logic [NB_addr-1:0] dest_q;
  logic [NB_data-1:0] w_data_q;
  logic               zero_q;
  logic               sign_q;
  logic [2:0]         mem_q;
  logic [1:0]         wb_q;
  logic [25:0]        jump_q;

  assign alu_op   = in_ex[EX_ALUOP_HI:EX_ALUOP_LO];
  assign op_b     = in_ex[EX_ALUSRC] ? in_inmediato : in_reg2;
  assign branch_d = in_branch + (in_inmediato << 2);

  ex_alu #(
    .NB_data (NB_data),
    .NB_addr (NB_addr)
  ) u_alu (
    .a_i      (in_reg1),
    .b_i      (op_b),
    .shamt_i  (in_shamt),
    .op_i     (alu_op),
    .result_o (alu_res)
  );

`ifdef EX_LINK_EN
  logic unused_ex;
  assign unused_ex = in_ex[0];

  // Link (JAL/JALR/BxxAL) overrides both the ALU result and the RegDst choice.
  always_comb begin
    alu_d  = alu_res;
    dest_d = in_ex[EX_REGDST] ? in_rd : in_rt;
    if (in_ex[EX_LINK]) begin
      alu_d  = in_branch;
      dest_d = NB_addr'(LINK_REG);
    end
  end
`else
  logic unused_ex;
  assign unused_ex = ^in_ex[EX_LINK:0];

  assign alu_d  = alu_res;
  assign dest_d = in_ex[EX_REGDST] ? in_rd : in_rt;
`endif

  // Flags follow the value actually forwarded to MEM, i.e. after any link override.
  assign zero_d = (alu_d == '0);
  assign sign_d = alu_d[NB_data-1];

  // NOTE: sequential state uses non-blocking assignments so all registers sample together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_q <= '0;
      alu_q    <= '0;
      dest_q   <= '0;
      w_data_q <= '0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      mem_q    <= '0;
      wb_q     <= '0;
      jump_q   <= '0;
    end else begin
      branch_q <= branch_d;
      alu_q    <= alu_d;
      dest_q   <= dest_d;
      w_data_q <= in_reg2;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
      mem_q    <= in_mem;
      wb_q     <= in_wb;
      jump_q   <= in_jump_reg;
    end
  end

  assign out_branch   = branch_q;
  assign out_alu      = alu_q;
  assign out_reg_dest = dest_q;
  assign out_w_data   = w_data_q;
  assign out_zero     = zero_q;
  assign out_sign     = sign_q;
  assign out_mem      = mem_q;
  assign out_wb       = wb_q;
  assign out_jump_reg = jump_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: reset behaviour, directed cases and
// randomized instructions compared against an arithmetic reference model.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_branch, in_reg1, in_reg2, in_inmediato;
  logic [7:0]  in_ex;
  logic [2:0]  in_mem;
  logic [1:0]  in_wb;
  logic [25:0] in_jump_reg;
  logic [4:0]  in_shamt, in_rt, in_rd;

  logic [31:0] out_branch, out_alu, out_w_data;
  logic [4:0]  out_reg_dest;
  logic        out_zero, out_sign;
  logic [2:0]  out_mem;
  logic [1:0]  out_wb;
  logic [25:0] out_jump_reg;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_branch, exp_alu, exp_w_data;
  logic [4:0]  exp_dest;
  logic        exp_zero, exp_sign;
  logic [2:0]  exp_mem;
  logic [1:0]  exp_wb;
  logic [25:0] exp_jump;

  ex_stage #(.NB_data(32), .NB_addr(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_branch    (in_branch),
    .in_ex        (in_ex),
    .in_mem       (in_mem),
    .in_wb        (in_wb),
    .in_reg1      (in_reg1),
    .in_reg2      (in_reg2),
    .in_inmediato (in_inmediato),
    .in_jump_reg  (in_jump_reg),
    .in_shamt     (in_shamt),
    .in_rt        (in_rt),
    .in_rd        (in_rd),
    .out_branch   (out_branch),
    .out_alu      (out_alu),
    .out_reg_dest (out_reg_dest),
    .out_w_data   (out_w_data),
    .out_zero     (out_zero),
    .out_sign     (out_sign),
    .out_mem      (out_mem),
    .out_wb       (out_wb),
    .out_jump_reg (out_jump_reg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference ALU built from the instruction-set meaning of each op.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    logic [4:0]  vs;
    logic [31:0] fill;
    int          sa, sb;
    vs = a[4:0];
    sa = int'(a);
    sb = int'(b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a + ~b + 32'd1;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~a & ~b;
      4'd6:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return b * (32'd1 << sh);
      4'd9:  return b / (32'd1 << sh);
      4'd10: begin
        fill = b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
        return (b >> sh) | fill;
      end
      4'd11: return b * (32'd1 << vs);
      4'd12: return b / (32'd1 << vs);
      4'd13: begin
        fill = b[31] ? ~(32'hFFFF_FFFF >> vs) : 32'd0;
        return (b >> vs) | fill;
      end
      4'd14: return {b[15:0], 16'h0000};
      default: return a;
    endcase
  endfunction

  task automatic predict();
    logic [31:0] b;
    b          = in_ex[6] ? in_inmediato : in_reg2;
    exp_alu    = ref_alu(in_ex[5:2], in_reg1, b, in_shamt);
    exp_dest   = in_ex[7] ? in_rd : in_rt;
`ifdef EX_LINK_EN
    if (in_ex[1]) begin
      exp_alu  = in_branch;
      exp_dest = 5'd31;
    end
`endif
    exp_zero   = (exp_alu == 32'd0);
    exp_sign   = exp_alu[31];
    exp_branch = in_branch + in_inmediato * 32'd4;
    exp_w_data = in_reg2;
    exp_mem    = in_mem;
    exp_wb     = in_wb;
    exp_jump   = in_jump_reg;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".alu"},    out_alu,               exp_alu);
    check({tag, ".dest"},   32'(out_reg_dest),     32'(exp_dest));
    check({tag, ".branch"}, out_branch,            exp_branch);
    check({tag, ".wdata"},  out_w_data,            exp_w_data);
    check({tag, ".zero"},   32'(out_zero),         32'(exp_zero));
    check({tag, ".sign"},   32'(out_sign),         32'(exp_sign));
    check({tag, ".mem"},    32'(out_mem),          32'(exp_mem));
    check({tag, ".wb"},     32'(out_wb),           32'(exp_wb));
    check({tag, ".jump"},   32'(out_jump_reg),     32'(exp_jump));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".alu"},    out_alu,           32'd0);
    check({tag, ".dest"},   32'(out_reg_dest), 32'd0);
    check({tag, ".branch"}, out_branch,        32'd0);
    check({tag, ".wdata"},  out_w_data,        32'd0);
    check({tag, ".flags"},  32'({out_zero, out_sign}), 32'd0);
    check({tag, ".ctl"},    32'({out_mem, out_wb}),    32'd0);
    check({tag, ".jump"},   32'(out_jump_reg), 32'd0);
  endtask

  task automatic rand_inputs();
    in_branch    = $urandom;
    in_ex        = 8'($urandom);
    in_mem       = 3'($urandom);
    in_wb        = 2'($urandom);
    in_reg1      = $urandom;
    in_reg2      = $urandom;
    in_inmediato = $urandom;
    in_jump_reg  = 26'($urandom);
    in_shamt     = 5'($urandom);
    in_rt        = 5'($urandom);
    in_rd        = 5'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held low with random inputs and a running clock.
    reset = 1'b0;
    rand_inputs();
    #1;
    check_zero("reset_init");
    for (int i = 0; i < 5; i++) begin
      rand_inputs();
      tick();
      check_zero("reset_hold");
    end
    @(negedge clk);
    reset = 1'b1;

    // LUI through the immediate path.
    in_ex = 8'b0111_1000; in_reg1 = 32'd1; in_reg2 = 32'd3; in_inmediato = 32'd2;
    in_rt = 5'd1; in_rd = 5'd2; in_branch = 32'h25; in_mem = 3'b001; in_wb = 2'b01;
    in_shamt = 5'd0; in_jump_reg = 26'h155_AAAA;
    tick();
    check("lui.alu",    out_alu,               32'h0002_0000);
    check("lui.dest",   32'(out_reg_dest),     32'd1);
    check("lui.branch", out_branch,            32'h2D);
    check("lui.wdata",  out_w_data,            32'd3);
    check("lui.zero",   32'(out_zero),         32'd0);
    check("lui.sign",   32'(out_sign),         32'd0);
    check("lui.mem",    32'(out_mem),          32'b001);
    check("lui.wb",     32'(out_wb),           32'b01);
    check("lui.jump",   32'(out_jump_reg),     32'h155_AAAA);

    // R-type ADD.
    in_ex = 8'b1000_0000; in_reg1 = 32'd1; in_reg2 = 32'd3; in_rd = 5'd2;
    tick();
    check("add.alu",  out_alu,           32'd4);
    check("add.dest", 32'(out_reg_dest), 32'd2);
    check("add.zero", 32'(out_zero),     32'd0);

    // SUB producing zero, then a negative result.
    in_ex = 8'b1000_0100; in_reg1 = 32'd3; in_reg2 = 32'd3;
    tick();
    check("sub0.alu",  out_alu,       32'd0);
    check("sub0.zero", 32'(out_zero), 32'd1);
    in_reg1 = 32'd1;
    tick();
    check("subn.alu",  out_alu,       32'hFFFF_FFFE);
    check("subn.sign", 32'(out_sign), 32'd1);
    check("subn.zero", 32'(out_zero), 32'd0);

    // Shift by shamt, signed vs unsigned compare.
    in_ex = 8'b1010_0000; in_reg2 = 32'd3; in_shamt = 5'd1;
    tick();
    check("sll.alu", out_alu, 32'd6);
    in_ex = 8'b1001_1000; in_reg1 = 32'hFFFF_FFFF; in_reg2 = 32'd1;
    tick();
    check("slt.alu", out_alu, 32'd1);
    in_ex = 8'b1001_1100;
    tick();
    check("sltu.alu",  out_alu,       32'd0);
    check("sltu.zero", 32'(out_zero), 32'd1);

    // Backward branch with a negative offset.
    in_inmediato = 32'hFFFF_FFFF; in_branch = 32'h25;
    tick();
    check("bneg.branch", out_branch, 32'h21);

    // Link override (or its absence in the default build).
    in_ex = 8'b1000_0010; in_branch = 32'h40; in_reg1 = 32'd5; in_reg2 = 32'd7;
    in_rd = 5'd9; in_rt = 5'd4;
    tick();
`ifdef EX_LINK_EN
    check("link.alu",  out_alu,           32'h40);
    check("link.dest", 32'(out_reg_dest), 32'd31);
`else
    check("link.alu",  out_alu,           32'd12);
    check("link.dest", 32'(out_reg_dest), 32'd9);
`endif
    check("link.zero", 32'(out_zero), 32'd0);

    // Every ALU op once with random operands against the model.
    for (int op = 0; op < 16; op++) begin
      rand_inputs();
      in_ex[5:2] = 4'(op);
      predict();
      tick();
      check_all($sformatf("op%0d", op));
    end

    // Random instructions; some force equal operands to exercise the zero flag.
    for (int i = 0; i < 60; i++) begin
      rand_inputs();
      if (i % 4 == 0) begin
        in_reg1 = in_reg2;
        in_ex[6] = 1'b0;
      end
      predict();
      tick();
      check_all($sformatf("rnd%0d", i));
    end

    // Asynchronous reset mid-operation discards the registered result.
    rand_inputs();
    in_ex[5:2] = 4'd15; in_reg1 = 32'hDEAD_BEEF;
    predict();
    tick();
    check_all("pre_rst");
    rand_inputs();
    reset = 1'b0;
    #1;
    check_zero("async_rst");
    tick();
    check_zero("rst_edge");
    @(negedge clk);
    reset = 1'b1;
    rand_inputs();
    predict();
    tick();
    check_all("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
